// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the ALU-sharing controller.
// Build option ALU_SHARE_FIXED_PRIO_EN is consumed by rr_grant and alu_share_ctrl.
package alu_ctrl_pkg;

  localparam int unsigned FUN_W = 4;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_CMP   = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Unit group selected by the ALU decoder.
  function automatic logic [1:0] fun_group(input logic [FUN_W-1:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester command/response ports and ALU issue/return ports of alu_share_ctrl.
// master = requesters plus ALU environment, slave = the controller.
interface alu_share_ctrl_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4
);
  import alu_ctrl_pkg::*;

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       REQ_VALID;
  logic [NUM_REQ-1:0]       REQ_READY;
  logic [NUM_REQ*WIDTH-1:0] REQ_A;
  logic [NUM_REQ*WIDTH-1:0] REQ_B;
  logic [NUM_REQ*FUN_W-1:0] REQ_FUN;
  logic [NUM_REQ-1:0]       RSP_VALID;
  logic [NUM_REQ-1:0]       RSP_READY;
  logic [WIDTH-1:0]         RSP_RESULT;
  logic [WIDTH-1:0]         ALU_A;
  logic [WIDTH-1:0]         ALU_B;
  logic [FUN_W-1:0]         ALU_FUN;
  logic                     ALU_EN;
  logic [WIDTH-1:0]         ALU_OUT;
  logic                     BUSY;
  logic [IDX_W-1:0]         OWNER;

  modport master (
    output REQ_VALID, REQ_A, REQ_B, REQ_FUN, RSP_READY, ALU_OUT,
    input  REQ_READY, RSP_VALID, RSP_RESULT, ALU_A, ALU_B, ALU_FUN, ALU_EN, BUSY, OWNER
  );

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, REQ_FUN, RSP_READY, ALU_OUT,
    output REQ_READY, RSP_VALID, RSP_RESULT, ALU_A, ALU_B, ALU_FUN, ALU_EN, BUSY, OWNER
  );

endinterface

// File: rtl/alu_share_ctrl_rr_grant.sv
// Combinational one-hot grant: first request searching upward from i_ptr+1 with wrap.
// With ALU_SHARE_FIXED_PRIO_EN defined the lowest index wins and there is no pointer input.
module rr_grant #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifndef ALU_SHARE_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

`ifdef ALU_SHARE_FIXED_PRIO_EN
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    // Descending scan so the lowest set index is written last.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    logic w_found;
    int   w_j;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_j = (int'(i_ptr) + k) % int'(NUM_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IDX_W'(w_j);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between NUM_REQ requesters: grant, issue, wait ALU_LAT, return result.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input logic               CLK,
  input logic               RST,
  alu_share_ctrl_if.slave   bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

  state_e             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [FUN_W-1:0]   r_alu_fun;
  logic               r_alu_en;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic [IDX_W-1:0]   r_ptr;
`endif

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_req_ready;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .i_req   (bus.REQ_VALID),
`ifndef ALU_SHARE_FIXED_PRIO_EN
    .i_ptr   (r_ptr),
`endif
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Grant is only offered in IDLE and never while reset is held.
  assign w_req_ready = (r_state == IDLE && !RST) ? w_grant : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_alu_en    <= 1'b0;
      r_rsp_valid <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      r_ptr       <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      r_alu_en <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_alu_a   <= bus.REQ_A[int'(w_idx) * int'(WIDTH) +: WIDTH];
            r_alu_b   <= bus.REQ_B[int'(w_idx) * int'(WIDTH) +: WIDTH];
            r_alu_fun <= bus.REQ_FUN[int'(w_idx) * int'(FUN_W) +: FUN_W];
            r_owner   <= w_idx;
            r_alu_en  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= CNT_W'(ALU_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // Last wait cycle: ALU_OUT is valid now.
          if (r_cnt == CNT_W'(1)) begin
            r_result    <= bus.ALU_OUT;
            r_rsp_valid <= NUM_REQ'(1) << r_owner;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.RSP_READY[r_owner]) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            r_ptr       <= r_owner;
`endif
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.REQ_READY  = w_req_ready;
  assign bus.RSP_VALID  = r_rsp_valid;
  assign bus.RSP_RESULT = r_result;
  assign bus.ALU_A      = r_alu_a;
  assign bus.ALU_B      = r_alu_b;
  assign bus.ALU_FUN    = r_alu_fun;
  assign bus.ALU_EN     = r_alu_en;
  assign bus.BUSY       = r_busy;
  assign bus.OWNER      = r_owner;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each fed by a small ALU model whose output is only valid in its latency window.
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(16), .NUM_REQ(4)) if1 ();
  alu_share_ctrl_if #(.WIDTH(16), .NUM_REQ(4)) if3 ();

  alu_share_ctrl #(.WIDTH(16), .NUM_REQ(4), .ALU_LAT(1)) u_dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (if1)
  );

  alu_share_ctrl #(.WIDTH(16), .NUM_REQ(4), .ALU_LAT(3)) u_dut3 (
    .CLK (clk),
    .RST (rst),
    .bus (if3)
  );

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] fun);
    logic [15:0] r;
    r = '0;
    case (fun_group(fun))
      GRP_ARITH: r = fun[0] ? a - b : a + b;
      GRP_LOGIC: begin
        case (fun[1:0])
          2'd0:    r = a & b;
          2'd1:    r = a | b;
          2'd2:    r = a ^ b;
          default: r = ~a;
        endcase
      end
      GRP_CMP:   r = fun[0] ? {15'd0, a == b} : {15'd0, a < b};
      default:   r = fun[0] ? a >> b[3:0] : a << b[3:0];
    endcase
    return r;
  endfunction

  // ALU models: output reads 0xDEAD outside the single valid cycle.
  logic        v1;
  logic [15:0] d1;
  logic [2:0]  v3;
  logic [15:0] d3 [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v3 <= '0;
    end else begin
      v1 <= if1.ALU_EN;
      v3 <= {v3[1:0], if3.ALU_EN};
    end
    d1    <= alu_f(if1.ALU_A, if1.ALU_B, if1.ALU_FUN);
    d3[0] <= alu_f(if3.ALU_A, if3.ALU_B, if3.ALU_FUN);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end

  assign if1.ALU_OUT = v1    ? d1    : 16'hDEAD;
  assign if3.ALU_OUT = v3[2] ? d3[2] : 16'hDEAD;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f);
    if1.REQ_VALID            = 4'b0001 << idx;
    if1.REQ_A[idx*16 +: 16]  = a;
    if1.REQ_B[idx*16 +: 16]  = b;
    if1.REQ_FUN[idx*4 +: 4]  = f;
  endtask

  task automatic drive3(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f);
    if3.REQ_VALID            = 4'b0001 << idx;
    if3.REQ_A[idx*16 +: 16]  = a;
    if3.REQ_B[idx*16 +: 16]  = b;
    if3.REQ_FUN[idx*4 +: 4]  = f;
  endtask

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    logic [15:0] res;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [3:0] oh;
    logic [3:0] exp_g [5];
    int k;

    vecs[0] = '{idx: 1, a: 16'h0005, b: 16'h0003, fun: 4'b0000, res: 16'h0008};
    vecs[1] = '{idx: 2, a: 16'h0010, b: 16'h0003, fun: 4'b0001, res: 16'h000D};
    vecs[2] = '{idx: 3, a: 16'hF0F0, b: 16'h0FF0, fun: 4'b0100, res: 16'h00F0};
    vecs[3] = '{idx: 0, a: 16'hF000, b: 16'h000F, fun: 4'b0101, res: 16'hF00F};
    vecs[4] = '{idx: 1, a: 16'hFFFF, b: 16'h00FF, fun: 4'b0110, res: 16'hFF00};
    vecs[5] = '{idx: 2, a: 16'h0003, b: 16'h0005, fun: 4'b1000, res: 16'h0001};
    vecs[6] = '{idx: 0, a: 16'h0001, b: 16'h0004, fun: 4'b1100, res: 16'h0010};
    vecs[7] = '{idx: 3, a: 16'h8000, b: 16'h000F, fun: 4'b1101, res: 16'h0001};
    vecs[8] = '{idx: 2, a: 16'hFFFF, b: 16'h0001, fun: 4'b0000, res: 16'h0000};

`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

    if1.REQ_VALID = '0; if1.REQ_A = '0; if1.REQ_B = '0; if1.REQ_FUN = '0; if1.RSP_READY = '0;
    if3.REQ_VALID = '0; if3.REQ_A = '0; if3.REQ_B = '0; if3.REQ_FUN = '0; if3.RSP_READY = '0;

    // Reset state, sampled while reset is still held.
    rst = 1'b1;
    tick();
    tick();
    check("rst busy", if1.BUSY, 1'b0);
    check("rst rsp_valid", if1.RSP_VALID, 4'b0000);
    check("rst alu_en", if1.ALU_EN, 1'b0);
    check("rst owner", if1.OWNER, 2'd0);
    check("rst alu_a", if1.ALU_A, 16'h0000);
    check("rst result", if1.RSP_RESULT, 16'h0000);
    check("rst req_ready", if1.REQ_READY, 4'b0000);
    check("rst busy lat3", if3.BUSY, 1'b0);
    rst = 1'b0;
    tick();

    // Single-transaction vectors on the ALU_LAT=1 instance.
    for (int n = 0; n < 9; n++) begin
      oh = 4'b0001 << vecs[n].idx;
      drive1(vecs[n].idx, vecs[n].a, vecs[n].b, vecs[n].fun);
      #1;
      check($sformatf("vec%0d grant", n), if1.REQ_READY, oh);
      tick();
      if1.REQ_VALID = '0;
      check($sformatf("vec%0d alu_en", n), if1.ALU_EN, 1'b1);
      check($sformatf("vec%0d alu_a", n), if1.ALU_A, vecs[n].a);
      check($sformatf("vec%0d alu_b", n), if1.ALU_B, vecs[n].b);
      check($sformatf("vec%0d alu_fun", n), if1.ALU_FUN, vecs[n].fun);
      check($sformatf("vec%0d owner", n), if1.OWNER, vecs[n].idx);
      check($sformatf("vec%0d busy", n), if1.BUSY, 1'b1);
      tick();
      check($sformatf("vec%0d alu_en low", n), if1.ALU_EN, 1'b0);
      check($sformatf("vec%0d early rsp", n), if1.RSP_VALID, 4'b0000);
      tick();
      check($sformatf("vec%0d rsp_valid", n), if1.RSP_VALID, oh);
      check($sformatf("vec%0d result", n), if1.RSP_RESULT, vecs[n].res);
      if1.RSP_READY = oh;
      tick();
      if1.RSP_READY = '0;
      check($sformatf("vec%0d rsp done", n), if1.RSP_VALID, 4'b0000);
      check($sformatf("vec%0d idle", n), if1.BUSY, 1'b0);
    end

    // Contention: all requesters valid, responses accepted at once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if1.REQ_VALID = 4'hF;
    if1.RSP_READY = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      k = 0;
      while (if1.REQ_READY == 4'b0000 && k < 20) begin
        tick();
        k++;
      end
      check($sformatf("contention grant %0d", g), if1.REQ_READY, exp_g[g]);
      tick();
    end
    if1.REQ_VALID = '0;
    tick();
    tick();
    tick();
    if1.RSP_READY = '0;
    check("contention drained", if1.BUSY, 1'b0);

    // Backpressure with non-owner RSP_READY and a non-granted requester toggling valid.
    if1.REQ_A[15:0] = 16'h0001;
    if1.REQ_B[15:0] = 16'h0001;
    if1.REQ_FUN[3:0] = 4'b0000;
    drive1(2, 16'h0007, 16'h0002, 4'b0001);
    #1;
    check("bp grant", if1.REQ_READY, 4'b0100);
    tick();
    if1.REQ_VALID = '0;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      if1.RSP_READY = 4'b1011;
      if1.REQ_VALID = (c % 2 == 1) ? 4'b0001 : 4'b0000;
      #1;
      check($sformatf("bp rsp_valid %0d", c), if1.RSP_VALID, 4'b0100);
      check($sformatf("bp result %0d", c), if1.RSP_RESULT, 16'h0005);
      check($sformatf("bp req_ready %0d", c), if1.REQ_READY, 4'b0000);
      check($sformatf("bp busy %0d", c), if1.BUSY, 1'b1);
      tick();
    end
    if1.RSP_READY = 4'b0100;
    if1.REQ_VALID = 4'b0001;
    #1;
    check("bp accept no comb grant", if1.REQ_READY, 4'b0000);
    tick();
    if1.RSP_READY = '0;
    check("bp rsp cleared", if1.RSP_VALID, 4'b0000);
    check("bp regrant next cycle", if1.REQ_READY, 4'b0001);
    tick();
    if1.REQ_VALID = '0;
    check("bp next owner", if1.OWNER, 2'd0);
    check("bp next alu_en", if1.ALU_EN, 1'b1);
    tick();
    tick();
    check("bp next rsp_valid", if1.RSP_VALID, 4'b0001);
    check("bp next result", if1.RSP_RESULT, 16'h0002);
    if1.RSP_READY = 4'b0001;
    tick();
    if1.RSP_READY = '0;

    // ALU_LAT=3: capture exactly three cycles after ALU_EN, RSP_VALID at t+5.
    drive3(1, 16'h00FF, 16'h0F0F, 4'b0100);
    #1;
    check("lat3 grant", if3.REQ_READY, 4'b0010);
    tick();
    if3.REQ_VALID = '0;
    check("lat3 alu_en", if3.ALU_EN, 1'b1);
    check("lat3 alu_fun", if3.ALU_FUN, 4'b0100);
    tick();
    check("lat3 t+2 alu_en", if3.ALU_EN, 1'b0);
    check("lat3 t+2 rsp", if3.RSP_VALID, 4'b0000);
    tick();
    check("lat3 t+3 rsp", if3.RSP_VALID, 4'b0000);
    tick();
    check("lat3 t+4 rsp", if3.RSP_VALID, 4'b0000);
    check("lat3 t+4 busy", if3.BUSY, 1'b1);
    tick();
    check("lat3 t+5 rsp", if3.RSP_VALID, 4'b0010);
    check("lat3 t+5 result", if3.RSP_RESULT, 16'h000F);
    if3.RSP_READY = 4'b0010;
    tick();
    if3.RSP_READY = '0;
    check("lat3 done", if3.BUSY, 1'b0);

    // Reset while waiting on the ALU aborts the operation.
    drive3(3, 16'h0001, 16'h0002, 4'b0000);
    #1;
    tick();
    if3.REQ_VALID = '0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst busy", if3.BUSY, 1'b0);
    check("midrst rsp_valid", if3.RSP_VALID, 4'b0000);
    check("midrst alu_en", if3.ALU_EN, 1'b0);
    check("midrst owner", if3.OWNER, 2'd0);
    check("midrst alu_a", if3.ALU_A, 16'h0000);
    check("midrst result", if3.RSP_RESULT, 16'h0000);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("midrst quiet %0d", c), if3.RSP_VALID, 4'b0000);
    end
    if3.REQ_A[15:0]  = 16'h0002;
    if3.REQ_B[15:0]  = 16'h0002;
    if3.REQ_FUN[3:0] = 4'b0000;
    if3.REQ_VALID    = 4'b1001;
    #1;
    check("midrst req0 first", if3.REQ_READY, 4'b0001);
    tick();
    if3.REQ_VALID = '0;
    tick();
    tick();
    tick();
    tick();
    check("midrst serve rsp", if3.RSP_VALID, 4'b0001);
    check("midrst serve result", if3.RSP_RESULT, 16'h0004);
    if3.RSP_READY = 4'b0001;
    tick();
    if3.RSP_READY = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
